// File: rtl/hs32_mem_pkg.sv
// Shared definitions for the hs32 memory arbiter: FSM state encodings and owner constants.
package hs32_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_EXEC  = 1'b1;

endpackage

// File: rtl/hs32_arb_pick.sv
// Winner selection between fetch and exec requesters.
// ARB_RR_EN selects round-robin on ties; otherwise exec has fixed priority over fetch.
module hs32_arb_pick
    import hs32_mem_pkg::*;
(
    input  logic reqf,
    input  logic reqx,
`ifdef ARB_RR_EN
    input  logic last_gnt,
`endif
    output logic win
);

    always_comb begin
        win = GNT_FETCH;
        if (reqf && reqx) begin
`ifdef ARB_RR_EN
            win = ~last_gnt;
`else
            win = GNT_EXEC;
`endif
        end else if (reqx) begin
            win = GNT_EXEC;
        end
    end

endmodule

// File: rtl/hs32_mem_arbiter.sv
// Two-requester (fetch/exec) single-port memory arbiter with fully registered outputs.
// Optional macro ARB_RR_EN enables round-robin tie-breaking instead of exec priority.
//
// state   | meaning
// IDLE    | waiting for a request; latches the winner's command on grant
// BUSY    | validm high, command held until readym is sampled
// RESP    | owner's rdy pulses for this one cycle, then back to IDLE
module hs32_mem_arbiter
    import hs32_mem_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reqf,
    input  logic [DW-1:0] addrf,
    output logic          rdyf,
    input  logic          reqx,
    input  logic [DW-1:0] addrx,
    input  logic          rwx,
    input  logic [DW-1:0] dtwx,
    output logic          rdyx,
    output logic [DW-1:0] dtr,
    output logic [DW-1:0] addrm,
    output logic          rwm,
    output logic [DW-1:0] dtwm,
    output logic          validm,
    input  logic          readym,
    input  logic [DW-1:0] dtrm,
    output logic          gnt
);

    state_t state;
    logic   win;
    logic   grant;

    assign grant = (state == ST_IDLE) && (reqf || reqx);

`ifdef ARB_RR_EN
    logic last_gnt;

    // Resets to exec so that fetch wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_gnt <= GNT_EXEC;
        end else if (grant) begin
            last_gnt <= win;
        end
    end

    hs32_arb_pick u_pick (
        .reqf     (reqf),
        .reqx     (reqx),
        .last_gnt (last_gnt),
        .win      (win)
    );
`else
    hs32_arb_pick u_pick (
        .reqf (reqf),
        .reqx (reqx),
        .win  (win)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            validm <= 1'b0;
            rdyf   <= 1'b0;
            rdyx   <= 1'b0;
            rwm    <= 1'b0;
            gnt    <= GNT_FETCH;
            addrm  <= '0;
            dtwm   <= '0;
            dtr    <= '0;
        end else begin
            rdyf <= 1'b0;
            rdyx <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        gnt    <= win;
                        validm <= 1'b1;
                        state  <= ST_BUSY;
                        if (win == GNT_EXEC) begin
                            addrm <= addrx;
                            rwm   <= rwx;
                            dtwm  <= dtwx;
                        end else begin
                            addrm <= addrf;
                            rwm   <= 1'b0;
                            dtwm  <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (readym) begin
                        validm <= 1'b0;
                        // Writes keep the previously returned read data.
                        if (!rwm) begin
                            dtr <= dtrm;
                        end
                        rdyf  <= (gnt == GNT_FETCH);
                        rdyx  <= (gnt == GNT_EXEC);
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/hs32_mem_arbiter.md
HS32_MEM_ARBITER -- requirements
Module: hs32_mem_arbiter

Interface
REQ-001 Parameter DW, default 32, width of address and data buses.
REQ-002 clk  in  1  single core clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 reqf  in  1  fetch read request, level, held until rdyf.
REQ-005 addrf  in  DW  fetch address.
REQ-006 rdyf  out  1  fetch completion, one-cycle pulse.
REQ-007 reqx  in  1  exec request, level, held until rdyx.
REQ-008 addrx  in  DW  exec address.
REQ-009 rwx  in  1  exec direction: 1 = write, 0 = read.
REQ-010 dtwx  in  DW  exec write data.
REQ-011 rdyx  out  1  exec completion, one-cycle pulse.
REQ-012 dtr  out  DW  read data returned to the completing requester.
REQ-013 addrm  out  DW  memory address.
REQ-014 rwm  out  1  memory direction.
REQ-015 dtwm  out  DW  memory write data.
REQ-016 validm  out  1  memory request valid.
REQ-017 readym  in  1  memory accept/complete.
REQ-018 dtrm  in  DW  memory read data.
REQ-019 gnt  out  1  owner of the current or last transaction: 0 = fetch, 1 = exec.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUSY, RESP.
REQ-021 IDLE: when any req is high, the arbiter SHALL pick a winner, register its addr, rw and dtw plus gnt, and move to BUSY.
REQ-022 Fetch transactions SHALL drive rwm=0 and dtwm=0.
REQ-023 BUSY: validm SHALL be 1 and addrm/rwm/dtwm SHALL hold stable until readym is sampled high.
REQ-024 BUSY with readym=1: the arbiter SHALL register dtrm into dtr (reads only; writes leave dtr unchanged) and move to RESP.
REQ-025 RESP: the owner's rdy SHALL be 1 for exactly one cycle, the other rdy 0; the FSM SHALL then return to IDLE.
REQ-026 Minimum latency SHALL be: req sampled in IDLE at edge N, validm in cycle N+1, rdy in cycle N+2 when readym=1.
REQ-027 Each extra cycle of readym=0 in BUSY SHALL add exactly one cycle of latency, with no upper bound.
REQ-028 A requester SHALL drop req at the edge on which it samples rdy; the arbiter SHALL ignore req in BUSY and RESP.
REQ-029 A req deasserted during BUSY SHALL NOT abort the transaction; rdy SHALL still pulse.
REQ-030 readym SHALL be ignored in IDLE and RESP.
REQ-031 When both requesters are high in IDLE, the default policy SHALL grant exec.
REQ-032 When only one requester is high, it SHALL be granted regardless of policy.
REQ-033 dtr and gnt SHALL hold their values until the next capture or grant.
REQ-034 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-035 While reset=0, the FSM SHALL be IDLE and validm, rdyf, rdyx, rwm, gnt = 0, and addrm, dtwm, dtr = 0, applied asynchronously.
REQ-036 Reset asserted during BUSY SHALL drop validm immediately; no rdy SHALL be issued for the abandoned transaction.

Configuration
REQ-037 With macro ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the requester not granted last time wins, and the last-grant bit resets to exec so fetch wins the first tie.
REQ-038 Without ARB_RR_EN, the policy SHALL be fixed priority exec > fetch and no last-grant state SHALL exist.

Structure
REQ-039 The FSM state encodings and the owner constants GNT_FETCH=0 and GNT_EXEC=1 SHALL live in a shared include/package, hs32_mem_pkg.
REQ-040 Winner selection SHALL be a separate combinational sub-module, hs32_arb_pick, holding the only ARB_RR_EN-dependent logic.

Verification
REQ-041 Single fetch: reqf=1, addrf=0x1000, readym=1, dtrm=0xCAFEBABE -> validm in cycle 1, addrm=0x1000, rwm=0; rdyf in cycle 2 with dtr=0xCAFEBABE, gnt=0.
REQ-042 Exec write with stall: reqx=1, rwx=1, addrx=0x20, dtwx=0x6, readym low for 3 cycles -> validm high 4 cycles, dtwm=0x6 stable; rdyx in the following cycle; dtr unchanged.
REQ-043 Simultaneous reqf/reqx without ARB_RR_EN -> exec served first and fetch second; two back-to-back cycles of contention -> fetch starved while reqx stays high.
REQ-044 Simultaneous requests repeated 4 times with ARB_RR_EN -> gnt sequence 0,1,0,1.
REQ-045 reset driven low in the second BUSY cycle -> validm=0 asynchronously, no rdy pulse; after release, IDLE with all outputs 0.
REQ-046 reqx dropped mid-BUSY -> transaction completes and rdyx pulses once.
